// File: rtl/hand_collector.sv
// Collects encoded cards from the dealer into a hand, rejecting malformed and duplicate
// cards, then holds the complete hand for the evaluator until it is consumed or aborted.
module hand_collector #(
  parameter int NUM_CARDS = 5,
  parameter int CARD_W    = 6,
  parameter bit DUP_CHECK = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CARD_W-1:0]                 card_in,
  input  logic                              card_valid,
  output logic                              card_ready,
  input  logic                              abort,
  output logic [NUM_CARDS-1:0][CARD_W-1:0]  hand_out,
  output logic                              hand_valid,
  input  logic                              hand_ready,
  output logic [2:0]                        card_count,
  output logic                              bad_card,
  output logic                              dup_card
);

  typedef enum logic {COLLECT, PRESENT} state_t;

  state_t state;
  logic   is_dup;

  assign card_ready = (state == COLLECT);

  // Only slots below card_count hold cards of the current hand; the rest are stale.
  always_comb begin
    is_dup = 1'b0;
    for (int k = 0; k < NUM_CARDS; k++) begin
      if (DUP_CHECK && (3'(k) < card_count) &&
          (hand_out[k][CARD_W-1:1] == card_in[CARD_W-1:1]))
        is_dup = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= COLLECT;
      hand_out   <= '0;
      card_count <= 3'd0;
      hand_valid <= 1'b0;
      bad_card   <= 1'b0;
      dup_card   <= 1'b0;
    end else begin
      bad_card <= 1'b0;
      dup_card <= 1'b0;
      if (abort) begin
        state      <= COLLECT;
        card_count <= 3'd0;
        hand_valid <= 1'b0;
      end else begin
        case (state)
          COLLECT: begin
            if (card_valid) begin
              if (!card_in[0]) begin
                bad_card <= 1'b1;
              end else if (is_dup) begin
                dup_card <= 1'b1;
              end else begin
                for (int k = 0; k < NUM_CARDS; k++) begin
                  if (card_count == 3'(k))
                    hand_out[k] <= card_in;
                end
                card_count <= card_count + 3'd1;
                if (card_count == 3'(NUM_CARDS - 1)) begin
                  state      <= PRESENT;
                  hand_valid <= 1'b1;
                end
              end
            end
          end
          PRESENT: begin
            if (hand_ready) begin
              state      <= COLLECT;
              card_count <= 3'd0;
              hand_valid <= 1'b0;
            end
          end
          default: state <= COLLECT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hand_collector.sv
// Self-checking bench for hand_collector: directed scenarios plus a randomized run
// compared against a queue-based model of the hand being collected.
module tb_hand_collector;

  logic             clk;
  logic             rst;
  logic [5:0]       card_in;
  logic             card_valid;
  logic             card_ready;
  logic             abort;
  logic [4:0][5:0]  hand_out;
  logic             hand_valid;
  logic             hand_ready;
  logic [2:0]       card_count;
  logic             bad_card;
  logic             dup_card;

  logic             nd_card_ready;
  logic [4:0][5:0]  nd_hand_out;
  logic             nd_hand_valid;
  logic [2:0]       nd_card_count;
  logic             nd_bad_card;
  logic             nd_dup_card;

  int passed = 0;
  int total  = 0;

  logic [5:0] mq[$];
  bit         m_present;
  bit         m_bad;
  bit         m_dup;

  hand_collector #(.NUM_CARDS(5), .CARD_W(6), .DUP_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .card_valid(card_valid),
    .card_ready(card_ready), .abort(abort), .hand_out(hand_out),
    .hand_valid(hand_valid), .hand_ready(hand_ready), .card_count(card_count),
    .bad_card(bad_card), .dup_card(dup_card)
  );

  hand_collector #(.NUM_CARDS(5), .CARD_W(6), .DUP_CHECK(1'b0)) dut_nodup (
    .clk(clk), .rst(rst), .card_in(card_in), .card_valid(card_valid),
    .card_ready(nd_card_ready), .abort(abort), .hand_out(nd_hand_out),
    .hand_valid(nd_hand_valid), .hand_ready(hand_ready), .card_count(nd_card_count),
    .bad_card(nd_bad_card), .dup_card(nd_dup_card)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit in_hand(input logic [5:0] c);
    foreach (mq[i]) if (mq[i][5:1] == c[5:1]) return 1'b1;
    return 1'b0;
  endfunction

  // Drives one cycle of inputs, advances the hand model, then waits just past the edge.
  task automatic step(input bit cv, input logic [5:0] c, input bit ab, input bit hr);
    card_valid = cv;
    card_in    = c;
    abort      = ab;
    hand_ready = hr;
    m_bad = 1'b0;
    m_dup = 1'b0;
    if (ab) begin
      mq.delete();
      m_present = 1'b0;
    end else if (!m_present) begin
      if (cv) begin
        if (!c[0]) m_bad = 1'b1;
        else if (in_hand(c)) m_dup = 1'b1;
        else begin
          mq.push_back(c);
          if (mq.size() == 5) m_present = 1'b1;
        end
      end
    end else if (hr) begin
      mq.delete();
      m_present = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    card_valid = 1'b0;
    card_in = 6'h00;
    abort = 1'b0;
    hand_ready = 1'b0;
    mq.delete();
    m_present = 1'b0;
    m_bad = 1'b0;
    m_dup = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (card_count !== 3'd0) $display("FAIL reset_count got %0d want 0", card_count); else passed++;
    total++; if (hand_valid !== 1'b0) $display("FAIL reset_hand_valid got %b want 0", hand_valid); else passed++;
    total++; if (card_ready !== 1'b1) $display("FAIL reset_card_ready got %b want 1", card_ready); else passed++;
    total++; if ({bad_card, dup_card} !== 2'b00) $display("FAIL reset_pulses got %b want 00", {bad_card, dup_card}); else passed++;
    step(1, 6'h39, 0, 0);
    step(1, 6'h2B, 0, 0);
    step(1, 6'h1D, 0, 0);
    step(0, 6'h00, 0, 0);
    total++; if (card_count !== 3'd3) $display("FAIL pre_reset_count got %0d want 3", card_count); else passed++;
    rst = 1'b1;
    mq.delete();
    m_present = 1'b0;
    #1;
    total++; if (card_count !== 3'd0) $display("FAIL async_reset_count got %0d want 0", card_count); else passed++;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++; if (card_ready !== 1'b1) $display("FAIL release_card_ready got %b want 1", card_ready); else passed++;
    total++; if (card_count !== 3'd0) $display("FAIL release_count got %0d want 0", card_count); else passed++;
    total++; if ({bad_card, dup_card, hand_valid} !== 3'b000) $display("FAIL release_flags got %b want 000", {bad_card, dup_card, hand_valid}); else passed++;
  endtask

  task automatic test_fill();
    logic [5:0] cards [5] = '{6'h39, 6'h2B, 6'h1D, 6'h0F, 6'h31};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, cards[i], 0, 0);
      if (i == 3) begin
        total++; if (hand_valid !== 1'b0) $display("FAIL fill_early_valid got %b want 0", hand_valid); else passed++;
      end
    end
    total++; if (hand_valid !== 1'b1) $display("FAIL fill_hand_valid got %b want 1", hand_valid); else passed++;
    total++; if (card_count !== 3'd5) $display("FAIL fill_count got %0d want 5", card_count); else passed++;
    total++; if (card_ready !== 1'b0) $display("FAIL fill_card_ready got %b want 0", card_ready); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++; if (hand_out[i] !== cards[i]) $display("FAIL fill_slot%0d got %h want %h", i, hand_out[i], cards[i]); else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [4:0][5:0] held;
    held = hand_out;
    for (int i = 0; i < 4; i++) begin
      step(1, 6'h07, 0, 0);
      total++; if (hand_out !== held) $display("FAIL bp_hand_stable got %h want %h", hand_out, held); else passed++;
      total++; if ({hand_valid, card_count} !== {1'b1, 3'd5}) $display("FAIL bp_hold got %b want 1101", {hand_valid, card_count}); else passed++;
    end
    step(1, 6'h07, 0, 1);
    card_valid = 1'b0;
    hand_ready = 1'b0;
    total++; if (card_count !== 3'd0) $display("FAIL bp_release_count got %0d want 0", card_count); else passed++;
    total++; if (card_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", card_ready); else passed++;
    total++; if (hand_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", hand_valid); else passed++;
  endtask

  task automatic test_duplicate();
    do_reset();
    step(1, 6'h39, 0, 0);
    step(1, 6'h38, 0, 0);
    total++; if ({bad_card, dup_card} !== 2'b10) $display("FAIL dup_bad_pulse got %b want 10", {bad_card, dup_card}); else passed++;
    total++; if (card_count !== 3'd1) $display("FAIL dup_bad_count got %0d want 1", card_count); else passed++;
    step(1, 6'h39, 0, 0);
    total++; if ({bad_card, dup_card} !== 2'b01) $display("FAIL dup_dup_pulse got %b want 01", {bad_card, dup_card}); else passed++;
    total++; if (card_count !== 3'd1) $display("FAIL dup_dup_count got %0d want 1", card_count); else passed++;
    total++; if (nd_card_count !== 3'd2) $display("FAIL nodup_count got %0d want 2", nd_card_count); else passed++;
    total++; if (nd_hand_out[1] !== 6'h39) $display("FAIL nodup_slot1 got %h want 39", nd_hand_out[1]); else passed++;
    total++; if (nd_dup_card !== 1'b0) $display("FAIL nodup_pulse got %b want 0", nd_dup_card); else passed++;
    step(0, 6'h00, 0, 0);
    total++; if ({bad_card, dup_card} !== 2'b00) $display("FAIL dup_pulse_len got %b want 00", {bad_card, dup_card}); else passed++;
  endtask

  task automatic test_abort();
    do_reset();
    step(1, 6'h39, 0, 0);
    step(1, 6'h2B, 0, 0);
    step(1, 6'h1D, 0, 0);
    step(1, 6'h0F, 0, 0);
    total++; if (card_count !== 3'd4) $display("FAIL abort_pre_count got %0d want 4", card_count); else passed++;
    step(1, 6'h31, 1, 0);
    total++; if (card_count !== 3'd0) $display("FAIL abort_count got %0d want 0", card_count); else passed++;
    total++; if ({bad_card, dup_card, hand_valid} !== 3'b000) $display("FAIL abort_flags got %b want 000", {bad_card, dup_card, hand_valid}); else passed++;
    step(1, 6'h30, 1, 0);
    total++; if (bad_card !== 1'b0) $display("FAIL abort_bad_suppressed got %b want 0", bad_card); else passed++;
    step(1, 6'h39, 0, 0);
    step(1, 6'h2B, 0, 0);
    step(1, 6'h1D, 0, 0);
    step(1, 6'h0F, 0, 0);
    step(1, 6'h31, 0, 0);
    total++; if (hand_valid !== 1'b1) $display("FAIL abort_refill_valid got %b want 1", hand_valid); else passed++;
    step(0, 6'h00, 1, 0);
    total++; if (hand_valid !== 1'b0) $display("FAIL abort_present_valid got %b want 0", hand_valid); else passed++;
    total++; if ({card_ready, card_count} !== {1'b1, 3'd0}) $display("FAIL abort_present_state got %b want 1000", {card_ready, card_count}); else passed++;
  endtask

  task automatic test_random();
    int hands = 0;
    int cycles = 0;
    bit cv, ab, hr, hs;
    logic [5:0] c;
    bit dup_seen;
    do_reset();
    while (hands < 1000 && cycles < 60000) begin
      cv = ($urandom_range(3) != 0);
      c  = {3'($urandom_range(7)), 2'($urandom_range(3)), ($urandom_range(7) != 0)};
      ab = ($urandom_range(199) == 0);
      hr = ($urandom_range(2) == 0);
      hs = m_present && hr && !ab;
      if (hs) begin
        dup_seen = 1'b0;
        for (int i = 0; i < 5; i++)
          for (int j = i + 1; j < 5; j++)
            if (hand_out[i][5:1] == hand_out[j][5:1]) dup_seen = 1'b1;
        total++; if (dup_seen) $display("FAIL rand_hand_dups got %h want no repeated card", hand_out); else passed++;
        hands++;
      end
      step(cv, c, ab, hr);
      cycles++;
      total++; if (card_count !== 3'(mq.size())) $display("FAIL rand_count got %0d want %0d", card_count, mq.size()); else passed++;
      total++; if (hand_valid !== m_present) $display("FAIL rand_hand_valid got %b want %b", hand_valid, m_present); else passed++;
      total++; if (card_ready !== !m_present) $display("FAIL rand_card_ready got %b want %b", card_ready, !m_present); else passed++;
      total++; if ({bad_card, dup_card} !== {m_bad, m_dup}) $display("FAIL rand_pulses got %b want %b", {bad_card, dup_card}, {m_bad, m_dup}); else passed++;
      for (int i = 0; i < mq.size(); i++) begin
        total++; if (hand_out[i] !== mq[i]) $display("FAIL rand_slot%0d got %h want %h", i, hand_out[i], mq[i]); else passed++;
      end
    end
    total++; if (hands < 1000) $display("FAIL rand_timeout got %0d hands want 1000", hands); else passed++;
    card_valid = 1'b0;
    hand_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    card_valid = 1'b0;
    card_in = 6'h00;
    abort = 1'b0;
    hand_ready = 1'b0;
    test_reset();
    test_fill();
    test_backpressure();
    test_duplicate();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
